// File: rtl/ocx_dlx_xlx_init_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : ocx_dlx_xlx_init_seq_if
// Purpose  : Bundles the PHY bring-up handshake between the DLx init sequencer
//            and its environment (transceiver wizard, DLx, link control).
// Signals  : start, send_first            - bring-up request / release policy
//            gtwiz_*_tx_done_in           - PHY TX ready indications
//            gtwiz_*_rx_done_in           - PHY RX ready indications
//            pb_io_o0_rx_run_lane[7:0]    - per-lane sync detected
//            retrain_req                  - DLx request to re-centre RX eye
//            gtwiz_reset_all_out          - full PHY reset
//            gtwiz_reset_rx_datapath_out  - PHY RX datapath reset
//            dlx_reset                    - holds DLx in reset
//            io_pb_o0_rx_init_done[7:0]   - per-lane RX init complete
//            init_fail, retry_cnt[2:0], seq_state[3:0] - status / debug
// Modports : master - the sequencer; slave - the environment driving it.
// Revision : 1.0 - initial release
// ============================================================================
interface ocx_dlx_xlx_init_seq_if;
  logic       start;
  logic       send_first;
  logic       gtwiz_reset_tx_done_in;
  logic       gtwiz_buffbypass_tx_done_in;
  logic       gtwiz_reset_rx_done_in;
  logic       gtwiz_buffbypass_rx_done_in;
  logic [7:0] pb_io_o0_rx_run_lane;
  logic       retrain_req;
  logic       gtwiz_reset_all_out;
  logic       gtwiz_reset_rx_datapath_out;
  logic       dlx_reset;
  logic [7:0] io_pb_o0_rx_init_done;
  logic       init_fail;
  logic [2:0] retry_cnt;
  logic [3:0] seq_state;

  modport master (
    input  start, send_first,
    input  gtwiz_reset_tx_done_in, gtwiz_buffbypass_tx_done_in,
    input  gtwiz_reset_rx_done_in, gtwiz_buffbypass_rx_done_in,
    input  pb_io_o0_rx_run_lane, retrain_req,
    output gtwiz_reset_all_out, gtwiz_reset_rx_datapath_out, dlx_reset,
    output io_pb_o0_rx_init_done, init_fail, retry_cnt, seq_state
  );

  modport slave (
    output start, send_first,
    output gtwiz_reset_tx_done_in, gtwiz_buffbypass_tx_done_in,
    output gtwiz_reset_rx_done_in, gtwiz_buffbypass_rx_done_in,
    output pb_io_o0_rx_run_lane, retrain_req,
    input  gtwiz_reset_all_out, gtwiz_reset_rx_datapath_out, dlx_reset,
    input  io_pb_o0_rx_init_done, init_fail, retry_cnt, seq_state
  );
endinterface
`default_nettype wire

// File: rtl/ocx_dlx_xlx_init_seq.sv
`default_nettype none
// ============================================================================
// Module   : ocx_dlx_xlx_init_seq
// Purpose  : Brings up the transceiver PHY and releases the DLx: full PHY
//            reset pulse, wait for TX/RX ready, wait for lane sync, RX
//            datapath reset pulse, wait for RX ready, then LINKED. Timed waits
//            retry from the full reset up to MAX_RETRY times before FAIL.
// Ports    : opt_gckn - clock (rising edge)
//            reset    - synchronous, active-high
//            bus      - ocx_dlx_xlx_init_seq_if.master (handshake and status)
// Revision : 1.0 - initial release
// ============================================================================
module ocx_dlx_xlx_init_seq #(
  parameter int PULSE_CYCLES = 8,
  parameter int TIMEOUT_W    = 16,
  parameter int MAX_RETRY    = 3
) (
  input wire logic               opt_gckn,
  input wire logic               reset,
  ocx_dlx_xlx_init_seq_if.master bus
);

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    RST_ALL     = 4'd1,
    WAIT_TX     = 4'd2,
    WAIT_RX     = 4'd3,
    WAIT_SYNC   = 4'd4,
    RX_PULSE    = 4'd5,
    WAIT_RXDONE = 4'd6,
    LINKED      = 4'd7,
    FAIL        = 4'd8
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [TIMEOUT_W-1:0] timer;
  logic [7:0]           pulse_cnt;
  logic [2:0]           retry;
  logic [2:0]           retry_nxt;
  logic                 start_q;
  logic                 tx_ok;
  logic                 rx_ok;
  logic                 all_sync;
  logic                 start_fall;
  logic                 start_rise;
  logic                 timed;
  logic                 expired;
  logic                 pulse_last;
  logic                 rxdone_settled;
  logic                 timeout_hit;
  logic                 released;

  assign tx_ok      = bus.gtwiz_reset_tx_done_in & bus.gtwiz_buffbypass_tx_done_in;
  assign rx_ok      = bus.gtwiz_reset_rx_done_in & bus.gtwiz_buffbypass_rx_done_in;
  assign all_sync   = &bus.pb_io_o0_rx_run_lane;
  assign start_fall = start_q & ~bus.start;
  assign start_rise = ~start_q & bus.start;

  // WAIT_SYNC is deliberately absent: lane sync may take arbitrarily long.
  assign timed          = (state == WAIT_TX) || (state == WAIT_RX) || (state == WAIT_RXDONE);
  assign expired        = timed && (&timer);
  assign pulse_last     = (pulse_cnt == 8'(PULSE_CYCLES - 1));
  assign rxdone_settled = (32'(timer) >= 32'd4);

  always_comb begin
    state_nxt   = state;
    retry_nxt   = retry;
    timeout_hit = 1'b0;
    if (start_fall && (state != IDLE) && (state != FAIL)) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state_nxt = RST_ALL;
            retry_nxt = 3'd0;
          end
        end
        RST_ALL:     if (pulse_last) state_nxt = WAIT_TX;
        WAIT_TX:     if (tx_ok) state_nxt = WAIT_RX; else timeout_hit = expired;
        WAIT_RX:     if (rx_ok) state_nxt = WAIT_SYNC; else timeout_hit = expired;
        WAIT_SYNC:   if (all_sync) state_nxt = RX_PULSE;
        RX_PULSE:    if (pulse_last) state_nxt = WAIT_RXDONE;
        WAIT_RXDONE: begin
          if (rx_ok && rxdone_settled) state_nxt = LINKED;
          else timeout_hit = expired;
        end
        LINKED: begin
          // Loss of TX needs a full re-init; a retrain only re-centres RX.
          if (!tx_ok) state_nxt = RST_ALL;
          else if (bus.retrain_req) state_nxt = RX_PULSE;
        end
        FAIL: begin
          if (start_rise) begin
            state_nxt = RST_ALL;
            retry_nxt = 3'd0;
          end
        end
        default: state_nxt = IDLE;
      endcase
      if (timeout_hit) begin
        if (retry == 3'(MAX_RETRY)) begin
          state_nxt = FAIL;
        end else begin
          retry_nxt = retry + 3'd1;
          state_nxt = RST_ALL;
        end
      end
    end
  end

  always_ff @(posedge opt_gckn) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      pulse_cnt <= '0;
      retry     <= 3'd0;
      start_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      retry   <= retry_nxt;
      start_q <= bus.start;
      if (state_nxt != state) begin
        timer     <= '0;
        pulse_cnt <= '0;
      end else begin
        if (timed) timer <= timer + TIMEOUT_W'(1);
        if ((state == RST_ALL) || (state == RX_PULSE)) pulse_cnt <= pulse_cnt + 8'd1;
      end
    end
  end

  // DLx release point depends on which direction trains first.
  assign released = bus.send_first ? ((state >= WAIT_RX) && (state <= LINKED))
                                   : ((state >= WAIT_SYNC) && (state <= LINKED));

  assign bus.gtwiz_reset_all_out         = (state == IDLE) || (state == RST_ALL) || (state == FAIL);
  assign bus.gtwiz_reset_rx_datapath_out = (state == RX_PULSE);
  assign bus.dlx_reset                   = ~released;
  assign bus.io_pb_o0_rx_init_done       = (state == LINKED) ? {8{rx_ok}} : 8'h00;
  assign bus.init_fail                   = (state == FAIL);
  assign bus.retry_cnt                   = retry;
  assign bus.seq_state                   = state;

endmodule
`default_nettype wire

// File: tb/tb_ocx_dlx_xlx_init_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ocx_dlx_xlx_init_seq
// Purpose  : Self-checking bench for ocx_dlx_xlx_init_seq. A behavioural model
//            tracks the bring-up phase and its age in cycles; a compare
//            process checks every DUT output against it each cycle. Directed
//            scenarios pin the model with literal expectations, then random
//            stimulus runs against the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ocx_dlx_xlx_init_seq;
  localparam int P  = 8;
  localparam int TW = 4;
  localparam int MR = 3;

  // Phase numbering as published for the debug output.
  localparam int PH_IDLE = 0, PH_RST = 1, PH_WTX = 2, PH_WRX = 3, PH_SYNC = 4;
  localparam int PH_PULSE = 5, PH_WRXD = 6, PH_LINK = 7, PH_FAIL = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ocx_dlx_xlx_init_seq_if bus();

  ocx_dlx_xlx_init_seq #(.PULSE_CYCLES(P), .TIMEOUT_W(TW), .MAX_RETRY(MR)) dut (
    .opt_gckn (clk),
    .reset    (rst),
    .bus      (bus)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int n_ra, n_dp, n_rel;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_ph = PH_IDLE;   // current phase
  int m_age = 0;        // cycles spent in current phase
  int m_retry = 0;
  bit m_prev_start = 1'b0;

  function automatic bit m_tx_ok();
    return bus.gtwiz_reset_tx_done_in && bus.gtwiz_buffbypass_tx_done_in;
  endfunction
  function automatic bit m_rx_ok();
    return bus.gtwiz_reset_rx_done_in && bus.gtwiz_buffbypass_rx_done_in;
  endfunction

  always @(posedge clk) begin
    int nph;
    bit waiting, gave_up;
    if (rst) begin
      m_ph = PH_IDLE; m_age = 0; m_retry = 0; m_prev_start = 1'b0;
    end else begin
      nph = m_ph;
      waiting = 1'b0;
      if (m_prev_start && !bus.start && m_ph != PH_IDLE && m_ph != PH_FAIL) nph = PH_IDLE;
      else begin
        if (m_ph == PH_IDLE && bus.start) begin nph = PH_RST; m_retry = 0; end
        if ((m_ph == PH_RST || m_ph == PH_PULSE) && m_age == P - 1) nph = m_ph + 1;
        if (m_ph == PH_WTX) begin if (m_tx_ok()) nph = PH_WRX; else waiting = 1'b1; end
        if (m_ph == PH_WRX) begin if (m_rx_ok()) nph = PH_SYNC; else waiting = 1'b1; end
        if (m_ph == PH_SYNC && bus.pb_io_o0_rx_run_lane == 8'hFF) nph = PH_PULSE;
        if (m_ph == PH_WRXD) begin if (m_rx_ok() && m_age >= 4) nph = PH_LINK; else waiting = 1'b1; end
        if (m_ph == PH_LINK) begin
          if (!m_tx_ok()) nph = PH_RST;
          else if (bus.retrain_req) nph = PH_PULSE;
        end
        if (m_ph == PH_FAIL && !m_prev_start && bus.start) begin nph = PH_RST; m_retry = 0; end
        gave_up = waiting && (m_age == (1 << TW) - 1);
        if (gave_up) begin
          if (m_retry == MR) nph = PH_FAIL;
          else begin m_retry = m_retry + 1; nph = PH_RST; end
        end
      end
      m_age = (nph == m_ph) ? m_age + 1 : 0;
      m_ph = nph;
      m_prev_start = bus.start;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit rel;
      rel = (m_ph >= (bus.send_first ? PH_WRX : PH_SYNC)) && (m_ph <= PH_LINK);
      chk("m_state", bus.seq_state, m_ph);
      chk("m_reset_all", bus.gtwiz_reset_all_out, (m_ph == PH_IDLE || m_ph == PH_RST || m_ph == PH_FAIL));
      chk("m_rx_dp", bus.gtwiz_reset_rx_datapath_out, (m_ph == PH_PULSE));
      chk("m_dlx_reset", bus.dlx_reset, !rel);
      chk("m_init_done", bus.io_pb_o0_rx_init_done, (m_ph == PH_LINK && m_rx_ok()) ? 8'hFF : 8'h00);
      chk("m_init_fail", bus.init_fail, (m_ph == PH_FAIL));
      chk("m_retry", bus.retry_cnt, m_retry);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_state(input int target, input int budget, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      if (int'(bus.seq_state) == PH_RST && bus.gtwiz_reset_all_out) n_ra++;
      if (bus.gtwiz_reset_rx_datapath_out) n_dp++;
      if (int'(bus.seq_state) == PH_WRX && !bus.dlx_reset) n_rel++;
      n++;
    end while (int'(bus.seq_state) != target && n < budget);
    chk({tag, "_reached"}, bus.seq_state, target);
  endtask

  task automatic set_tx(input bit v);
    bus.gtwiz_reset_tx_done_in = v;
    bus.gtwiz_buffbypass_tx_done_in = v;
  endtask

  task automatic set_rx(input bit v);
    bus.gtwiz_reset_rx_done_in = v;
    bus.gtwiz_buffbypass_rx_done_in = v;
  endtask

  initial begin
    int txm, rxm;
    rst = 1'b1;
    bus.start = 1'b0; bus.send_first = 1'b1; bus.retrain_req = 1'b0;
    bus.pb_io_o0_rx_run_lane = 8'hFF;
    set_tx(1'b1); set_rx(1'b1);
    @(posedge clk); #1 chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_state", bus.seq_state, 0);
    chk("rst_reset_all", bus.gtwiz_reset_all_out, 1);
    chk("rst_rx_dp", bus.gtwiz_reset_rx_datapath_out, 0);
    chk("rst_dlx", bus.dlx_reset, 1);
    chk("rst_done", bus.io_pb_o0_rx_init_done, 0);
    chk("rst_fail", bus.init_fail, 0);
    #1 rst = 1'b0;
    @(negedge clk);

    // Full bring-up, send_first=1.
    #1 bus.start = 1'b1;
    n_ra = 0; n_dp = 0; n_rel = 0;
    wait_state(PH_LINK, 60, "A_link");
    chk("A_reset_all_cycles", n_ra, 8);
    chk("A_rx_dp_cycles", n_dp, 8);
    chk("A_dlx_rel_in_wait_rx", n_rel, 1);
    chk("A_init_done", bus.io_pb_o0_rx_init_done, 8'hFF);
    chk("A_dlx", bus.dlx_reset, 0);

    // Retrain from LINKED.
    #1 bus.retrain_req = 1'b1;
    @(negedge clk);
    chk("R_init_done", bus.io_pb_o0_rx_init_done, 8'h00);
    chk("R_state", bus.seq_state, PH_PULSE);
    #1 bus.retrain_req = 1'b0;
    n_dp = 1;
    wait_state(PH_LINK, 40, "R_link");
    chk("R_rx_dp_cycles", n_dp, 8);

    // Loss of TX beats retrain.
    #1 bus.retrain_req = 1'b1; bus.gtwiz_reset_tx_done_in = 1'b0;
    @(negedge clk);
    chk("T_state", bus.seq_state, PH_RST);
    chk("T_rx_dp", bus.gtwiz_reset_rx_datapath_out, 0);
    #1 bus.retrain_req = 1'b0; set_tx(1'b1);
    wait_state(PH_LINK, 60, "T_link");

    // Reset in cycle 3 of the RX datapath pulse.
    #1 bus.retrain_req = 1'b1;
    @(negedge clk);
    #1 bus.retrain_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("X_pulse_c3", bus.gtwiz_reset_rx_datapath_out, 1);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("X_rx_dp", bus.gtwiz_reset_rx_datapath_out, 0);
    chk("X_state", bus.seq_state, 0);
    chk("X_reset_all", bus.gtwiz_reset_all_out, 1);
    chk("X_dlx", bus.dlx_reset, 1);
    chk("X_done", bus.io_pb_o0_rx_init_done, 0);
    chk("X_fail", bus.init_fail, 0);
    #1 rst = 1'b0; bus.start = 1'b0; set_tx(1'b0);
    @(negedge clk);

    // Timeouts with TX never ready: three retries, then FAIL.
    #1 bus.start = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      wait_state(PH_WTX, 40, "F_wtx");
      wait_state(PH_RST, 40, "F_retry");
      chk("F_retry_cnt", bus.retry_cnt, k);
    end
    wait_state(PH_WTX, 40, "F_wtx4");
    wait_state(PH_FAIL, 40, "F_fail");
    chk("F_retry_final", bus.retry_cnt, 3);
    chk("F_init_fail", bus.init_fail, 1);
    #1 bus.start = 1'b0;
    @(negedge clk);
    chk("F_hold", bus.seq_state, PH_FAIL);
    #1 bus.start = 1'b1;
    @(negedge clk);
    chk("F_restart", bus.seq_state, PH_RST);
    chk("F_restart_retry", bus.retry_cnt, 0);
    chk("F_restart_fail", bus.init_fail, 0);

    // send_first=0, lanes not all synced: WAIT_SYNC never times out.
    #1 bus.send_first = 1'b0; set_tx(1'b1); bus.pb_io_o0_rx_run_lane = 8'h7F;
    wait_state(PH_SYNC, 40, "S_sync");
    repeat (40) @(negedge clk);
    chk("S_stay", bus.seq_state, PH_SYNC);
    chk("S_dlx", bus.dlx_reset, 0);
    chk("S_retry", bus.retry_cnt, 0);
    #1 bus.pb_io_o0_rx_run_lane = 8'hFF;
    @(negedge clk);
    chk("S_pulse", bus.seq_state, PH_PULSE);

    // Randomized run against the model.
    txm = 0; rxm = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      #1;
      if (c % 150 == 0) begin
        txm = $urandom_range(0, 3);
        rxm = $urandom_range(0, 3);
      end
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 79) == 0) bus.start = ~bus.start;
      if ($urandom_range(0, 49) == 0) bus.send_first = ~bus.send_first;
      bus.retrain_req = ($urandom_range(0, 29) == 0);
      bus.pb_io_o0_rx_run_lane = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF;
      bus.gtwiz_reset_tx_done_in      = (txm == 2) ? 1'b0 : (txm == 1) ? 1'($urandom) : ($urandom_range(0, 39) != 0);
      bus.gtwiz_buffbypass_tx_done_in = (txm == 1) ? 1'($urandom) : 1'b1;
      bus.gtwiz_reset_rx_done_in      = (rxm == 2) ? 1'b0 : (rxm == 1) ? 1'($urandom) : ($urandom_range(0, 39) != 0);
      bus.gtwiz_buffbypass_rx_done_in = (rxm == 1) ? 1'($urandom) : 1'b1;
    end
    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
